// File: rtl/ss_scan_ctrl.sv
// Multiplexed common-anode seven-segment scan controller with a tear-free display register.
// Optional build macro SS_LZ_SUPPRESS_EN enables leading-zero suppression of the upper digits.
module ss_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 50000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [4*NUM_DIGITS-1:0]   wr_data,
    input  logic [NUM_DIGITS-1:0]     wr_blank,
    output logic [6:0]                seg_n,
    output logic [NUM_DIGITS-1:0]     an_n
);

    localparam int CW = $clog2(PRESCALE);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_BLANK,
        ST_DRIVE
    } state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic                      pend_full_q, pend_full_d;
    logic [4*NUM_DIGITS-1:0]   pend_data_q, pend_data_d;
    logic [NUM_DIGITS-1:0]     pend_blank_q, pend_blank_d;
    logic [4*NUM_DIGITS-1:0]   disp_data_q, disp_data_d;
    logic [NUM_DIGITS-1:0]     disp_blank_q, disp_blank_d;
    logic [6:0]                seg_n_q, seg_n_d;
    logic [NUM_DIGITS-1:0]     an_n_q, an_n_d;

    logic                      slot_end;
    logic                      frame_end;
    logic                      xfer;
    logic [NUM_DIGITS-1:0]     lz_mask;
    logic [NUM_DIGITS-1:0]     eff_blank;
    logic [3:0]                cur_nib;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        s = 7'h7F;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign slot_end  = (cnt_q == CNT_LAST);
    assign frame_end = slot_end && (idx_q == IDX_LAST);
    assign xfer      = wr_valid && !pend_full_q;
    assign wr_ready  = !pend_full_q;
    assign seg_n     = seg_n_q;
    assign an_n      = an_n_q;

    always_comb begin
        cnt_d = slot_end ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // Commit only at frame end so a frame never mixes old and new digits.
    always_comb begin
        pend_full_d  = pend_full_q;
        pend_data_d  = pend_data_q;
        pend_blank_d = pend_blank_q;
        disp_data_d  = disp_data_q;
        disp_blank_d = disp_blank_q;
        if (frame_end && pend_full_q) begin
            disp_data_d  = pend_data_q;
            disp_blank_d = pend_blank_q;
            pend_full_d  = 1'b0;
        end
        if (xfer) begin
            pend_data_d  = wr_data;
            pend_blank_d = wr_blank;
            pend_full_d  = 1'b1;
        end
    end

`ifdef SS_LZ_SUPPRESS_EN
    always_comb begin
        lz_mask = '0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            lz_mask[i] = ((disp_data_q >> (4 * i)) == '0);
        end
    end
`else
    assign lz_mask = '0;
`endif

    assign eff_blank = disp_blank_q | lz_mask;
    assign cur_nib   = disp_data_q[4*idx_q +: 4];

    always_comb begin
        state_d = state_q;
        seg_n_d = 7'h7F;
        an_n_d  = '1;
        case (state_q)
            ST_BLANK: begin
                state_d = ST_DRIVE;
            end
            ST_DRIVE: begin
                if (slot_end) begin
                    state_d = ST_BLANK;
                end
                if (!eff_blank[idx_q]) begin
                    seg_n_d        = hex_to_seg(cur_nib);
                    an_n_d[idx_q]  = 1'b0;
                end
            end
            default: begin
                state_d = ST_BLANK;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_BLANK;
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_full_q  <= 1'b0;
            pend_data_q  <= '0;
            pend_blank_q <= '0;
            disp_data_q  <= '0;
            disp_blank_q <= '0;
            seg_n_q      <= 7'h7F;
            an_n_q       <= '1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_full_q  <= pend_full_d;
            pend_data_q  <= pend_data_d;
            pend_blank_q <= pend_blank_d;
            disp_data_q  <= disp_data_d;
            disp_blank_q <= disp_blank_d;
            seg_n_q      <= seg_n_d;
            an_n_q       <= an_n_d;
        end
    end

endmodule

// File: tb/tb_ss_scan_ctrl.sv
// Bench for ss_scan_ctrl (4 digits, 4-cycle slots): frame-position reference model plus
// directed and random writes, compared every cycle.
module tb_ss_scan_ctrl;

    localparam int ND = 4;
    localparam int P  = 4;
    localparam int FR = ND * P;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [15:0] wr_data = '0;
    logic [3:0]  wr_blank = '0;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;

    ss_scan_ctrl #(.NUM_DIGITS(ND), .PRESCALE(P)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .wr_blank (wr_blank),
        .seg_n    (seg_n),
        .an_n     (an_n)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference state: what the display shows, what is queued, and where in the frame we are.
    logic [15:0] m_disp = '0;
    logic [3:0]  m_dblank = '0;
    logic [15:0] m_pdata = '0;
    logic [3:0]  m_pblank = '0;
    bit          m_pend = 1'b0;
    int          tc = 0;
    logic [6:0]  exp_seg = 7'h7F;
    logic [3:0]  exp_an = 4'hF;
    bit          last_xfer = 1'b0;

    function automatic logic [6:0] seg_of(input logic [3:0] h);
        logic [6:0] tbl [16];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return tbl[h];
    endfunction

    task automatic cycle(input bit v, input logic [15:0] d, input logic [3:0] b, input bit rn);
        int pos, slot, cn;
        logic [3:0] eff;
        bit commit, xf;
        @(negedge clk);
        check("seg_n", 32'(seg_n), 32'(exp_seg));
        check("an_n", 32'(an_n), 32'(exp_an));
        check("wr_ready", 32'(wr_ready), 32'(!m_pend));
        rst_n    = rn;
        wr_valid = v;
        wr_data  = d;
        wr_blank = b;
        @(posedge clk);
        if (!rn) begin
            m_disp = '0; m_dblank = '0; m_pend = 1'b0;
            tc = 0; exp_seg = 7'h7F; exp_an = 4'hF; last_xfer = 1'b0;
        end else begin
            pos  = tc % FR;
            slot = pos / P;
            cn   = pos % P;
            eff  = m_dblank;
`ifdef SS_LZ_SUPPRESS_EN
            for (int i = 1; i < ND; i++) begin
                if ((m_disp >> (4 * i)) == 16'h0) eff[i] = 1'b1;
            end
`endif
            if (cn == 0 || eff[slot]) begin
                exp_seg = 7'h7F;
                exp_an  = 4'hF;
            end else begin
                exp_seg = seg_of(4'((m_disp >> (4 * slot)) & 16'hF));
                exp_an  = 4'hF & ~(4'h1 << slot);
            end
            xf     = v && !m_pend;
            commit = (pos == FR - 1) && m_pend;
            if (commit) begin
                m_disp = m_pdata; m_dblank = m_pblank; m_pend = 1'b0;
            end
            if (xf) begin
                m_pdata = d; m_pblank = b; m_pend = 1'b1;
            end
            last_xfer = xf;
            tc++;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, $urandom, 4'h0, 1'b1);
    endtask

    task automatic put(input logic [15:0] d, input logic [3:0] b);
        bit acc = 1'b0;
        for (int k = 0; k < 200 && !acc; k++) begin
            cycle(1'b1, d, b, 1'b1);
            acc = last_xfer;
        end
        check("accept", 32'(acc), 32'd1);
    endtask

    initial begin
        bit found;
        @(posedge clk);
        for (int k = 0; k < 3; k++) cycle(1'b0, '0, '0, 1'b0);
        idle(20);
        put(16'h12AF, 4'h0);
        idle(40);
        put(16'hA5C3, 4'h0);
        put(16'h3B7E, 4'h0);
        idle(40);
        put(16'h8888, 4'b0101);
        idle(40);
        put(16'h0030, 4'h0);
        idle(40);
        put(16'h0000, 4'h0);
        idle(40);
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            if (tc % FR == FR - 1 && !m_pend) found = 1'b1;
            else idle(1);
        end
        check("commit_slot_found", 32'(found), 32'd1);
        cycle(1'b1, 16'h4D2E, 4'h0, 1'b1);
        idle(40);
        put(16'h9999, 4'h0);
        idle(5);
        cycle(1'b1, 16'h7777, 4'h0, 1'b0);
        cycle(1'b0, 16'h0, 4'h0, 1'b0);
        idle(40);
        for (int k = 0; k < 3000; k++) begin
            cycle($urandom_range(0, 3) == 0, 16'($urandom),
                  ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
                  $urandom_range(0, 499) != 0);
        end
        idle(40);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
